// File: rtl/life_step_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// life_step_engine: sweeps a source grid and writes one Game-of-Life generation
// into a separate destination grid using a three-row sliding window.
// Revision: 1.0
// ----------------------------------------------------------------------------
module life_step_engine #(
  parameter int WIDTH  = 80,
  parameter int HEIGHT = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [12:0] pop_count,
  output logic [6:0]  readX,
  output logic [5:0]  readY,
  input  logic        cellState,
  output logic        writeCell,
  output logic [6:0]  writeX,
  output logic [5:0]  writeY,
  output logic        writeValue
);

  localparam logic [6:0] LAST_COL = 7'(WIDTH - 1);
  localparam logic [5:0] ROWS     = 6'(HEIGHT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SHIFT   = 3'd2,
    S_COMPUTE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d, cur_q, cur_d, next_q, next_d;
  logic [6:0]       x_q, x_d;
  logic [5:0]       ld_q, ld_d;
  logic             ph_q, ph_d;
  logic [12:0]      pc_q, pc_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             wr_q, wr_d, wv_q, wv_d;
  logic [6:0]       wx_q, wx_d;
  logic [5:0]       wy_q, wy_d;
  logic [12:0]      pop_q, pop_d;

  logic [WIDTH+1:0] pad_p, pad_c, pad_n;
  logic [2:0]       wp, wc, wn;
  logic [3:0]       n;
  logic             live;

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    cur_d   = cur_q;
    next_d  = next_q;
    x_d     = x_q;
    ld_d    = ld_q;
    ph_d    = ph_q;
    pc_d    = pc_q;
    pop_d   = pop_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          prev_d  = '0;
          cur_d   = '0;
          next_d  = '0;
          ld_d    = '0;
          x_d     = '0;
          ph_d    = 1'b0;
          pc_d    = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Address is held for two cycles; the source data is valid in the second.
        if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d         = 1'b0;
          next_d[x_q]  = cellState;
          if (x_q == LAST_COL) begin
            x_d     = '0;
            state_d = (ld_q == 6'd0) ? S_SHIFT : S_COMPUTE;
          end else begin
            x_d = x_q + 7'd1;
          end
        end
      end
      S_SHIFT: begin
        prev_d  = cur_q;
        cur_d   = next_q;
        next_d  = '0;
        ld_d    = ld_q + 6'd1;
        x_d     = '0;
        ph_d    = 1'b0;
        state_d = (ld_d == ROWS) ? S_COMPUTE : S_LOAD;
      end
      S_COMPUTE: begin
        if (x_q == LAST_COL) begin
          x_d     = '0;
          state_d = (ld_q == ROWS) ? S_DONE : S_SHIFT;
        end else begin
          x_d = x_q + 7'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Registered write outputs are formed from the window as it will stand next
    // cycle, so each strobe lines up with the COMPUTE cycle it belongs to.
    pad_p = {1'b0, prev_d, 1'b0};
    pad_c = {1'b0, cur_d,  1'b0};
    pad_n = {1'b0, next_d, 1'b0};
    wp    = pad_p[x_d +: 3];
    wc    = pad_c[x_d +: 3];
    wn    = pad_n[x_d +: 3];
    n     = 4'(wp[0]) + 4'(wp[1]) + 4'(wp[2]) + 4'(wc[0]) + 4'(wc[2])
          + 4'(wn[0]) + 4'(wn[1]) + 4'(wn[2]);
    live  = (n == 4'd3) | (wc[1] & (n == 4'd2));

    busy_d = (state_d == S_LOAD) | (state_d == S_SHIFT) | (state_d == S_COMPUTE);
    done_d = (state_d == S_DONE);
    wr_d   = (state_d == S_COMPUTE);
    wv_d   = wr_d & live;
    wx_d   = wr_d ? x_d : wx_q;
    wy_d   = wr_d ? (ld_d - 6'd1) : wy_q;
    if (wv_d) begin
      pc_d = pc_d + 13'd1;
    end
    if (state_d == S_DONE) begin
      pop_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      prev_q  <= '0;
      cur_q   <= '0;
      next_q  <= '0;
      x_q     <= '0;
      ld_q    <= '0;
      ph_q    <= 1'b0;
      pc_q    <= '0;
      pop_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_q    <= 1'b0;
      wv_q    <= 1'b0;
      wx_q    <= '0;
      wy_q    <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      next_q  <= next_d;
      x_q     <= x_d;
      ld_q    <= ld_d;
      ph_q    <= ph_d;
      pc_q    <= pc_d;
      pop_q   <= pop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wr_q    <= wr_d;
      wv_q    <= wv_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pop_count  = pop_q;
  assign readX      = x_q;
  assign readY      = ld_q;
  assign writeCell  = wr_q;
  assign writeX     = wx_q;
  assign writeY     = wy_q;
  assign writeValue = wv_q;

endmodule
`default_nettype wire

// File: tb/tb_life_step_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_life_step_engine: drives source-grid patterns and compares the written
// destination grid against a dead-border Game-of-Life reference.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_life_step_engine;
  localparam int W   = 80;
  localparam int H   = 60;
  localparam int LAT = 2 * W * H + W * H + H + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, cellState = 1'b0;
  logic [12:0] pop_count;
  logic [6:0]  readX, writeX;
  logic [5:0]  readY, writeY;
  logic        writeCell, writeValue;

  life_step_engine #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .pop_count(pop_count), .readX(readX), .readY(readY), .cellState(cellState),
    .writeCell(writeCell), .writeX(writeX), .writeY(writeY), .writeValue(writeValue)
  );

  always #5 clk = ~clk;

  bit src[H][W];
  bit dst[H][W];
  bit refg[H][W];
  int ref_pop;

  int checks = 0;
  int failures = 0;
  int wr_count = 0, order_err = 0, oob = 0, done_count = 0;
  int exp_x = 0, exp_y = 0, busy_gap = 0;
  logic busy_at_done;

  // Source memory: data for an address appears one cycle after it is presented.
  always @(posedge clk)
    cellState <= (readY < H && readX < W) ? src[readY][readX] : 1'b0;

  // Destination memory plus a record of write order.
  always @(negedge clk) begin
    if (done) done_count++;
    if (writeCell) begin
      if (writeX != exp_x || writeY != exp_y) order_err++;
      if (writeX < W && writeY < H) dst[writeY][writeX] = writeValue;
      else oob++;
      wr_count++;
      if (exp_x == W - 1) begin exp_x = 0; exp_y++; end
      else exp_x++;
    end
  end

  task automatic clear_src();
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) src[y][x] = 1'b0;
  endtask

  task automatic random_src();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) src[y][x] = ($urandom_range(0, 2) == 0);
  endtask

  // Reference next generation; also primes dst with the inverse so any
  // unwritten cell shows up as a mismatch.
  task automatic compute_ref();
    int nb;
    ref_pop = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        nb = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (!(dx == 0 && dy == 0) && y + dy >= 0 && y + dy < H &&
                x + dx >= 0 && x + dx < W)
              nb += int'(src[y + dy][x + dx]);
        refg[y][x] = (nb == 3) || (src[y][x] && nb == 2);
        ref_pop += int'(refg[y][x]);
        dst[y][x] = !refg[y][x];
      end
  endtask

  function automatic int grid_mism();
    int m = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) if (dst[y][x] != refg[y][x]) m++;
    return m;
  endfunction

  // Starts a generation; lat = cycle offset of done from the start cycle, -1 on timeout.
  task automatic run_gen(input int pulse_at, output int lat);
    int k;
    wr_count = 0; order_err = 0; oob = 0; done_count = 0;
    exp_x = 0; exp_y = 0; busy_gap = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; k = 1;
    while (done !== 1'b1 && k < 20000) begin
      if (busy !== 1'b1) busy_gap++;
      start = (k + 1 == pulse_at);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    busy_at_done = busy;
    lat = (done === 1'b1) ? k : -1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    checks += 5;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_busy_done: busy=%b done=%b, need 0 0", busy, done);
    end
    if (writeCell !== 1'b0 || writeValue !== 1'b0) begin
      failures++; $display("FAIL reset_write: writeCell=%b writeValue=%b, need 0 0", writeCell, writeValue);
    end
    if (pop_count !== 13'd0) begin
      failures++; $display("FAIL reset_pop: got %0d, need 0", pop_count);
    end
    if (readX !== 7'd0 || readY !== 6'd0) begin
      failures++; $display("FAIL reset_read_addr: got (%0d,%0d), need (0,0)", readX, readY);
    end
    if (writeX !== 7'd0 || writeY !== 6'd0) begin
      failures++; $display("FAIL reset_write_addr: got (%0d,%0d), need (0,0)", writeX, writeY);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_empty();
    int lat;
    clear_src(); compute_ref(); run_gen(0, lat);
    checks += 6;
    if (lat !== LAT) begin
      failures++; $display("FAIL empty_latency: done at T+%0d, need T+%0d", lat, LAT);
    end
    if (busy_gap !== 0 || busy_at_done !== 1'b0) begin
      failures++; $display("FAIL empty_busy: low cycles=%0d busy_at_done=%b, need 0 0", busy_gap, busy_at_done);
    end
    if (wr_count !== W * H) begin
      failures++; $display("FAIL empty_writes: got %0d, need %0d", wr_count, W * H);
    end
    if (order_err !== 0) begin
      failures++; $display("FAIL empty_order: out-of-order writes=%0d, need 0", order_err);
    end
    if (grid_mism() !== 0) begin
      failures++; $display("FAIL empty_grid: mismatched cells=%0d, need 0", grid_mism());
    end
    if (pop_count !== 13'd0) begin
      failures++; $display("FAIL empty_pop: got %0d, need 0", pop_count);
    end
  endtask

  task automatic test_blinker();
    int lat;
    clear_src();
    for (int x = 10; x <= 12; x++) src[20][x] = 1'b1;
    compute_ref(); run_gen(0, lat);
    checks += 4;
    if (lat !== LAT) begin
      failures++; $display("FAIL blinker_latency: done at T+%0d, need T+%0d", lat, LAT);
    end
    if (grid_mism() !== 0) begin
      failures++; $display("FAIL blinker_grid: mismatched cells=%0d, need 0", grid_mism());
    end
    if (!(dst[19][11] && dst[20][11] && dst[21][11]) || dst[20][10] || dst[20][12]) begin
      failures++; $display("FAIL blinker_cells: col11 rows19..21=%b%b%b row20 x10,x12=%b%b, need 111 00",
                           dst[19][11], dst[20][11], dst[21][11], dst[20][10], dst[20][12]);
    end
    if (pop_count !== 13'd3) begin
      failures++; $display("FAIL blinker_pop: got %0d, need 3", pop_count);
    end
  endtask

  task automatic test_block_corner();
    int lat, diff;
    clear_src();
    src[0][0] = 1'b1; src[0][1] = 1'b1; src[1][0] = 1'b1; src[1][1] = 1'b1;
    compute_ref(); run_gen(0, lat);
    diff = 0;
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) if (dst[y][x] != src[y][x]) diff++;
    checks += 4;
    if (diff !== 0) begin
      failures++; $display("FAIL block_still_life: differing cells=%0d, need 0", diff);
    end
    if (pop_count !== 13'd4) begin
      failures++; $display("FAIL block_pop: got %0d, need 4", pop_count);
    end
    if (oob !== 0) begin
      failures++; $display("FAIL block_bounds: out-of-grid writes=%0d, need 0", oob);
    end
    if (wr_count !== W * H) begin
      failures++; $display("FAIL block_writes: got %0d, need %0d", wr_count, W * H);
    end
  endtask

  task automatic test_glider_edge();
    int lat;
    clear_src();
    src[57][78] = 1'b1; src[58][79] = 1'b1;
    src[59][77] = 1'b1; src[59][78] = 1'b1; src[59][79] = 1'b1;
    compute_ref(); run_gen(0, lat);
    checks += 3;
    if (grid_mism() !== 0) begin
      failures++; $display("FAIL glider_grid: mismatched cells=%0d, need 0", grid_mism());
    end
    if (pop_count !== 13'(ref_pop)) begin
      failures++; $display("FAIL glider_pop: got %0d, need %0d", pop_count, ref_pop);
    end
    if (oob !== 0 || order_err !== 0) begin
      failures++; $display("FAIL glider_writes: oob=%0d order_err=%0d, need 0 0", oob, order_err);
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    random_src(); compute_ref(); run_gen(100, lat);
    repeat (20) @(negedge clk);
    checks += 5;
    if (lat !== LAT) begin
      failures++; $display("FAIL busy_start_latency: done at T+%0d, need T+%0d", lat, LAT);
    end
    if (done_count !== 1 || busy !== 1'b0) begin
      failures++; $display("FAIL busy_start_done: pulses=%0d busy=%b, need 1 0", done_count, busy);
    end
    if (wr_count !== W * H) begin
      failures++; $display("FAIL busy_start_writes: got %0d, need %0d", wr_count, W * H);
    end
    if (grid_mism() !== 0) begin
      failures++; $display("FAIL busy_start_grid: mismatched cells=%0d, need 0", grid_mism());
    end
    if (pop_count !== 13'(ref_pop)) begin
      failures++; $display("FAIL busy_start_pop: got %0d, need %0d", pop_count, ref_pop);
    end
  endtask

  task automatic test_rst_mid();
    int lat, held;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4999) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks += 2;
    if (writeCell !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL rst_mid_outputs: writeCell=%b busy=%b done=%b, need 0 0 0", writeCell, busy, done);
    end
    if (pop_count !== 13'd0) begin
      failures++; $display("FAIL rst_mid_pop: got %0d, need 0", pop_count);
    end
    rst = 1'b0;
    held = wr_count;
    repeat (20) @(negedge clk);
    checks += 1;
    if (wr_count !== held || busy !== 1'b0) begin
      failures++; $display("FAIL rst_mid_quiet: writes after reset=%0d busy=%b, need 0 0", wr_count - held, busy);
    end
    random_src(); compute_ref(); run_gen(0, lat);
    checks += 2;
    if (grid_mism() !== 0 || lat !== LAT) begin
      failures++; $display("FAIL rst_mid_rerun: mismatched cells=%0d latency=%0d, need 0 %0d", grid_mism(), lat, LAT);
    end
    if (pop_count !== 13'(ref_pop)) begin
      failures++; $display("FAIL rst_mid_rerun_pop: got %0d, need %0d", pop_count, ref_pop);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    for (int r = 0; r < 2; r++) begin
      random_src(); compute_ref(); run_gen(0, lat);
      checks += 2;
      if (grid_mism() !== 0 || wr_count !== W * H) begin
        failures++; $display("FAIL b2b_grid[%0d]: mismatched cells=%0d writes=%0d, need 0 %0d", r, grid_mism(), wr_count, W * H);
      end
      if (pop_count !== 13'(ref_pop)) begin
        failures++; $display("FAIL b2b_pop[%0d]: got %0d, need %0d", r, pop_count, ref_pop);
      end
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_blinker();
    test_block_corner();
    test_glider_edge();
    test_start_while_busy();
    test_rst_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
